// File: rtl/apb_uart_host_pkg.sv
// Shared definitions for the UART APB host: FSM encoding, peripheral
// register word addresses and the default access timeout.
package apb_uart_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Peripheral registers as word addresses (byte offset >> 2).
  localparam logic [9:0] REG_OPS  = 10'd0;
  localparam logic [9:0] REG_TR   = 10'd1;
  localparam logic [9:0] REG_MODE = 10'd2;
  localparam logic [9:0] REG_BAUD = 10'd4;

  localparam int unsigned WAIT_W          = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/apb_wait_timer.sv
// Access-phase wait counter for APB initiators: clear, increment and a
// terminal flag raised when the count equals a non-zero limit.
module apb_wait_timer
  import apb_uart_host_pkg::*;
#(
  parameter int unsigned W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         terminal_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit means "never expire".
  assign terminal_o = (limit_i != '0) && (count_q == limit_i);

endmodule

// File: rtl/apb_uart_host.sv
// Single-outstanding APB initiator for the UART register port: one command
// in, one setup/access transfer out, one response strobe back.
module apb_uart_host
  import apb_uart_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sel,
  output logic        en,
  output logic [9:0]  addr,
  output logic        write_control,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        ready
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = WAIT_W'(TIMEOUT);

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timer_clear, timer_inc, timer_expired;

  apb_wait_timer #(
    .W (WAIT_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear),
    .inc_i      (timer_inc),
    .limit_i    (TIMEOUT_LIMIT),
    .terminal_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          write_d     = cmd_write;
          wdata_d     = cmd_wdata;
          timer_clear = 1'b1;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        timer_inc = ~ready;
        // ready is checked first so a completion on the terminal cycle is not an error.
        if (ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'd0 : read_data;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (timer_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign sel           = (state_q != ST_IDLE);
  assign en            = (state_q == ST_ACCESS);
  assign addr          = addr_q;
  assign write_control = write_q;
  assign write_data    = wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_apb_uart_host.sv
// Directed bench for apb_uart_host: zero-wait write, waited read, timeout,
// ready-on-terminal-cycle, back-to-back writes and reset during ACCESS.
module tb_apb_uart_host;
  import apb_uart_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sel;
  logic        en;
  logic [9:0]  addr;
  logic        write_control;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [9:0] b2b_addr [4];

  always #5 clk = ~clk;

  apb_uart_host #(
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .sel           (sel),
    .en            (en),
    .addr          (addr),
    .write_control (write_control),
    .write_data    (write_data),
    .read_data     (read_data),
    .ready         (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; read_data = '0; ready = 1'b0;
    b2b_addr[0] = REG_OPS; b2b_addr[1] = REG_TR;
    b2b_addr[2] = REG_MODE; b2b_addr[3] = REG_BAUD;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_sel", sel, 0);
    check("rst_en", en, 0);
    check("rst_addr", addr, 0);
    check("rst_wctl", write_control, 0);
    check("rst_wdata", write_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();

    // Zero-wait write to BAUD
    ready = 1'b1;
    issue(1'b1, REG_BAUD, 32'h0001_B200);
    check("w0_c0_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("w0_c1_sel", sel, 1);
    check("w0_c1_en", en, 0);
    check("w0_c1_wctl", write_control, 1);
    check("w0_c1_addr", addr, 4);
    check("w0_c1_wdata", write_data, 32'h0001_B200);
    tick();
    check("w0_c2_sel", sel, 1);
    check("w0_c2_en", en, 1);
    check("w0_c2_rsp_valid", rsp_valid, 0);
    tick();
    check("w0_c3_rsp_valid", rsp_valid, 1);
    check("w0_c3_rsp_err", rsp_err, 0);
    check("w0_c3_rsp_rdata", rsp_rdata, 0);
    check("w0_c3_cmd_ready", cmd_ready, 1);
    check("w0_c3_sel", sel, 0);
    tick();
    check("w0_c4_rsp_valid", rsp_valid, 0);

    // Read with 3 wait states
    ready = 1'b0;
    read_data = 32'hDEAD_BEEF;
    issue(1'b0, REG_OPS, 32'h0);
    tick();
    cmd_valid = 1'b0;
    check("r3_c1_en", en, 0);
    check("r3_c1_wctl", write_control, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) ready = 1'b1;
      check("r3_access_en", en, 1);
      check("r3_access_rsp_valid", rsp_valid, 0);
    end
    tick();
    ready = 1'b0;
    check("r3_c6_rsp_valid", rsp_valid, 1);
    check("r3_c6_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("r3_c6_rsp_err", rsp_err, 0);
    check("r3_c6_en", en, 0);
    tick();
    check("r3_c7_rsp_valid", rsp_valid, 0);
    check("r3_c7_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Timeout with ready held low
    read_data = 32'h1234_5678;
    issue(1'b0, REG_TR, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("to_access_en", en, 1);
      check("to_access_rsp_valid", rsp_valid, 0);
    end
    tick();
    check("to_c11_rsp_valid", rsp_valid, 1);
    check("to_c11_rsp_err", rsp_err, 1);
    check("to_c11_rsp_rdata", rsp_rdata, 0);
    check("to_c11_sel", sel, 0);
    check("to_c11_en", en, 0);
    tick();
    check("to_c12_rsp_valid", rsp_valid, 0);
    check("to_c12_err_hold", rsp_err, 1);
    check("to_c12_sel", sel, 0);

    // Ready on the 9th ACCESS cycle wins over the timeout
    read_data = 32'hCAFE_0002;
    issue(1'b0, REG_MODE, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 8) ready = 1'b1;
      check("tb_access_en", en, 1);
    end
    tick();
    ready = 1'b0;
    check("tb_c11_rsp_valid", rsp_valid, 1);
    check("tb_c11_rsp_err", rsp_err, 0);
    check("tb_c11_rsp_rdata", rsp_rdata, 32'hCAFE_0002);
    tick();

    // Back-to-back writes with cmd_valid held
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, b2b_addr[i], 32'hA500_0000 | i);
      check("b2b_accept_ready", cmd_ready, 1);
      if (i > 0) check("b2b_accept_rsp_valid", rsp_valid, 1);
      tick();
      cmd_addr  = 10'h3FF;
      cmd_wdata = 32'hFFFF_FFFF;
      check("b2b_setup_en", en, 0);
      check("b2b_setup_addr", addr, b2b_addr[i]);
      check("b2b_setup_wdata", write_data, 32'hA500_0000 | i);
      check("b2b_setup_cmd_ready", cmd_ready, 0);
      tick();
      check("b2b_access_en", en, 1);
      check("b2b_access_addr", addr, b2b_addr[i]);
      tick();
    end
    cmd_valid = 1'b0;
    check("b2b_last_rsp_valid", rsp_valid, 1);
    check("b2b_last_cmd_ready", cmd_ready, 1);
    tick();
    check("b2b_idle_sel", sel, 0);

    // Reset while waiting in ACCESS
    ready = 1'b0;
    issue(1'b1, REG_BAUD, 32'h5A5A_0001);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("rma_pre_en", en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rma_sel", sel, 0);
    check("rma_en", en, 0);
    check("rma_addr", addr, 0);
    check("rma_wctl", write_control, 0);
    check("rma_wdata", write_data, 0);
    check("rma_rsp_valid", rsp_valid, 0);
    check("rma_rsp_rdata", rsp_rdata, 0);
    check("rma_rsp_err", rsp_err, 0);
    check("rma_cmd_ready", cmd_ready, 1);
    tick();
    check("rma_next_rsp_valid", rsp_valid, 0);
    check("rma_next_sel", sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
